// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: opcodes, FSM state encoding, ALU op codes and select encodings for mc_control_alu
package mc_ctrl_pkg;
  localparam logic [5:0] OP_LD   = 6'h01;
  localparam logic [5:0] OP_ST   = 6'h02;
  localparam logic [5:0] OP_ADD  = 6'h10;
  localparam logic [5:0] OP_SUB  = 6'h11;
  localparam logic [5:0] OP_AND  = 6'h12;
  localparam logic [5:0] OP_OR   = 6'h13;
  localparam logic [5:0] OP_XOR  = 6'h14;
  localparam logic [5:0] OP_SLT  = 6'h15;
  localparam logic [5:0] OP_BEQ  = 6'h20;
  localparam logic [5:0] OP_BNE  = 6'h21;
  localparam logic [5:0] OP_J    = 6'h30;
  localparam logic [5:0] OP_LI   = 6'h31;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXECUTE, S_ALU_WB, S_BRANCH, S_JUMP, S_LOAD_IMM, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLL, ALU_SRL,
    ALU_SRA, ALU_SLT, ALU_SLTU, ALU_EQ, ALU_NE, ALU_PASS_B
  } alu_op_t;

  localparam logic [1:0] RWD_MDR        = 2'd0;
  localparam logic [1:0] RWD_ALUOUT     = 2'd1;
  localparam logic [1:0] RWD_IMM        = 2'd2;
  localparam logic [1:0] SRCB_FOUR      = 2'd0;
  localparam logic [1:0] SRCB_REGB      = 2'd1;
  localparam logic [1:0] SRCB_OFFSET_SH = 2'd2;
  localparam logic [1:0] SRCB_OFFSET    = 2'd3;
  localparam logic [1:0] PC_ALUOUT      = 2'd0;
  localparam logic [1:0] PC_JUMP        = 2'd1;
  localparam logic [1:0] PC_ALU         = 2'd2;

  function automatic alu_op_t aluOpFor(input logic [5:0] op);
    return op == OP_SUB ? ALU_SUB :
           op == OP_AND ? ALU_AND :
           op == OP_OR  ? ALU_OR  :
           op == OP_XOR ? ALU_XOR :
           op == OP_SLT ? ALU_SLT : ALU_ADD;
  endfunction
endpackage

// File: rtl/mc_alu.sv
// mc_alu: combinational ALU (alu_a, alu_b, alu_op -> alu_out); shifts use alu_b[5:0], compares yield 0/1
module mc_alu
  import mc_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = 64
) (
  input  logic [WORD_SIZE-1:0] alu_a,
  input  logic [WORD_SIZE-1:0] alu_b,
  input  logic [3:0]           alu_op,
  output logic [WORD_SIZE-1:0] alu_out
);
  localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1);
  logic [5:0] shAmt;
  assign shAmt = alu_b[5:0];
  always_comb begin
    alu_out = '0;
    case (alu_op)
      ALU_ADD:    alu_out = alu_a + alu_b;
      ALU_SUB:    alu_out = alu_a - alu_b;
      ALU_AND:    alu_out = alu_a & alu_b;
      ALU_OR:     alu_out = alu_a | alu_b;
      ALU_XOR:    alu_out = alu_a ^ alu_b;
      ALU_NOR:    alu_out = ~(alu_a | alu_b);
      ALU_SLL:    alu_out = alu_a << shAmt;
      ALU_SRL:    alu_out = alu_a >> shAmt;
      ALU_SRA:    alu_out = $unsigned($signed(alu_a) >>> shAmt);
      ALU_SLT:    alu_out = $signed(alu_a) < $signed(alu_b) ? ONE : '0;
      ALU_SLTU:   alu_out = alu_a < alu_b ? ONE : '0;
      ALU_EQ:     alu_out = alu_a == alu_b ? ONE : '0;
      ALU_NE:     alu_out = alu_a != alu_b ? ONE : '0;
      ALU_PASS_B: alu_out = alu_b;
      default:    alu_out = '0;
    endcase
  end
endmodule

// File: rtl/mc_control_alu.sv
// mc_control_alu: multicycle control FSM with datapath ALU; optional HALT opcode enabled by CTRL_HALT_EN
module mc_control_alu
  import mc_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = 64,
  parameter int OP_SIZE   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OP_SIZE-1:0]   opcode,
  input  logic [WORD_SIZE-1:0] alu_a,
  input  logic [WORD_SIZE-1:0] alu_b,
  output logic [WORD_SIZE-1:0] alu_out,
  output logic [3:0]           state,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 pc_write_combo,
  output logic                 mem_get_data,
  output logic                 mem_read,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic                 reg_track_select,
  output logic [1:0]           reg_write_data_select,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           pc_src,
  output logic [3:0]           alu_op
);
`ifdef CTRL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  state_t curState, nextState;
  logic [5:0] op;
  logic isAlu;
  assign op = 6'(opcode);
  assign isAlu = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT};
  assign state = curState;
  assign pc_write_combo = pc_write | (pc_write_cond & alu_out[0]);

  mc_alu #(.WORD_SIZE(WORD_SIZE)) alu (
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_op (alu_op),
    .alu_out(alu_out)
  );

  always_ff @(posedge clk)
    if (rst) curState <= S_FETCH;
    else curState <= nextState;

  always_comb begin
    nextState = S_FETCH;
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    mem_get_data = 1'b0;
    mem_read = 1'b1;
    ir_write = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    reg_track_select = 1'b0;
    reg_write_data_select = RWD_MDR;
    alu_src_b = SRCB_FOUR;
    pc_src = PC_ALUOUT;
    alu_op = ALU_ADD;
    case (curState)
      S_FETCH: begin
        nextState = S_DECODE;
        ir_write = 1'b1;
        pc_write = 1'b1;
        pc_src = PC_ALU;
      end
      S_DECODE: begin
        alu_src_b = SRCB_OFFSET_SH;
        nextState = (op == OP_LD || op == OP_ST) ? S_MEM_ADDR :
                    isAlu                        ? S_EXECUTE  :
                    (op == OP_BEQ || op == OP_BNE) ? S_BRANCH :
                    op == OP_J                   ? S_JUMP     :
                    op == OP_LI                  ? S_LOAD_IMM :
                    (HALT_EN && op == OP_HALT)   ? S_HALT     : S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_OFFSET;
        reg_track_select = 1'b1;
        nextState = op == OP_ST ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_get_data = 1'b1;
        nextState = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        reg_track_select = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_get_data = 1'b1;
        mem_read = 1'b0;
        reg_track_select = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REGB;
        alu_op = aluOpFor(op);
        nextState = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_write_data_select = RWD_ALUOUT;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REGB;
        alu_op = op == OP_BNE ? ALU_NE : ALU_EQ;
        pc_write_cond = 1'b1;
        reg_track_select = 1'b1;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src = PC_JUMP;
      end
      S_LOAD_IMM: begin
        reg_write = 1'b1;
        reg_write_data_select = RWD_IMM;
      end
      S_HALT: nextState = S_HALT;
      default: nextState = S_FETCH;
    endcase
    if (rst) begin
      pc_write = 1'b0;
      pc_write_cond = 1'b0;
      ir_write = 1'b0;
      reg_write = 1'b0;
      mem_read = 1'b1;
    end
  end
endmodule

// File: tb/tb_mc_control_alu.sv
// tb_mc_control_alu: directed self-checking bench for mc_control_alu and its ALU
module tb_mc_control_alu;
  logic clk, rst;
  logic [5:0] opcode;
  logic [63:0] alu_a, alu_b, alu_out;
  logic [3:0] state, alu_op;
  logic pc_write, pc_write_cond, pc_write_combo, mem_get_data, mem_read;
  logic ir_write, reg_write, alu_src_a, reg_track_select;
  logic [1:0] reg_write_data_select, alu_src_b, pc_src;
  logic [63:0] tA, tB, tOut;
  logic [3:0] tOp;
  int checks = 0;
  int fails = 0;
  int ldSeq[6] = '{0, 1, 2, 3, 4, 0};
  int stSeq[5] = '{0, 1, 2, 5, 0};

  mc_control_alu dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .state(state), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .pc_write_combo(pc_write_combo),
    .mem_get_data(mem_get_data), .mem_read(mem_read), .ir_write(ir_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a),
    .reg_track_select(reg_track_select),
    .reg_write_data_select(reg_write_data_select), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .alu_op(alu_op)
  );

  mc_alu #(.WORD_SIZE(64)) alu (.alu_a(tA), .alu_b(tB), .alu_op(tOp), .alu_out(tOut));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic aluCase(input string tag, input logic [3:0] o, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp);
    tOp = o;
    tA = a;
    tB = b;
    #1;
    checkVal(tag, tOut, exp);
  endtask

  initial begin
    rst = 1'b1;
    opcode = 6'h01;
    alu_a = '0;
    alu_b = '0;
    tA = '0;
    tB = '0;
    tOp = '0;
    cyc(2);
    checkVal("rst_state", state, 0);
    checkVal("rst_ir_write", ir_write, 0);
    checkVal("rst_pc_write", pc_write, 0);
    checkVal("rst_mem_read", mem_read, 1);
    rst = 1'b0;
    #1;
    checkVal("fetch_ir_write", ir_write, 1);
    checkVal("fetch_pc_write", pc_write, 1);
    checkVal("fetch_pc_src", pc_src, 2);
    checkVal("fetch_combo", pc_write_combo, 1);
    for (int i = 0; i < 6; i++) begin
      if (i != 0) cyc(1);
      checkVal("ld_state", state, 64'(ldSeq[i]));
      checkVal("ld_reg_write", reg_write, 64'(ldSeq[i] == 4));
      if (ldSeq[i] == 2) checkVal("ld_src_b", alu_src_b, 3);
      if (ldSeq[i] == 3) checkVal("ld_mem_get_data", mem_get_data, 1);
    end
    opcode = 6'h02;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) cyc(1);
      checkVal("st_state", state, 64'(stSeq[i]));
      checkVal("st_mem_read", mem_read, 64'(stSeq[i] != 5));
    end
    opcode = 6'h11;
    alu_a = 64'd5;
    alu_b = 64'd7;
    cyc(1);
    checkVal("dec_src_b", alu_src_b, 2);
    cyc(1);
    checkVal("sub_state", state, 6);
    checkVal("sub_alu_op", alu_op, 1);
    checkVal("sub_alu_out", alu_out, 64'hFFFF_FFFF_FFFF_FFFE);
    checkVal("sub_src_a", alu_src_a, 1);
    checkVal("sub_src_b", alu_src_b, 1);
    cyc(1);
    checkVal("alu_wb_state", state, 7);
    checkVal("alu_wb_reg_write", reg_write, 1);
    checkVal("alu_wb_rwd", reg_write_data_select, 1);
    cyc(1);
    checkVal("alu_end_state", state, 0);
    opcode = 6'h20;
    alu_a = 64'd9;
    alu_b = 64'd9;
    cyc(2);
    checkVal("beq_state", state, 8);
    checkVal("beq_alu_op", alu_op, 11);
    checkVal("beq_taken_combo", pc_write_combo, 1);
    checkVal("beq_pc_src", pc_src, 0);
    cyc(1);
    checkVal("beq_end_state", state, 0);
    alu_b = 64'd8;
    cyc(2);
    checkVal("beq_not_taken_combo", pc_write_combo, 0);
    cyc(1);
    opcode = 6'h21;
    cyc(2);
    checkVal("bne_alu_op", alu_op, 12);
    checkVal("bne_taken_combo", pc_write_combo, 1);
    cyc(1);
    opcode = 6'h30;
    cyc(2);
    checkVal("j_state", state, 9);
    checkVal("j_pc_src", pc_src, 1);
    checkVal("j_combo", pc_write_combo, 1);
    cyc(1);
    checkVal("j_end_state", state, 0);
    opcode = 6'h31;
    cyc(2);
    checkVal("li_state", state, 10);
    checkVal("li_rwd", reg_write_data_select, 2);
    checkVal("li_reg_write", reg_write, 1);
    cyc(1);
    checkVal("li_end_state", state, 0);
    opcode = 6'h15;
    alu_a = '1;
    alu_b = '0;
    cyc(2);
    checkVal("slt_alu_out", alu_out, 1);
    cyc(2);
    opcode = 6'h2A;
    cyc(1);
    checkVal("unk_decode", state, 1);
    cyc(1);
    checkVal("unk_end_state", state, 0);
    opcode = 6'h3F;
    cyc(2);
`ifdef CTRL_HALT_EN
    for (int i = 0; i < 10; i++) begin
      checkVal("halt_state", state, 11);
      checkVal("halt_reg_write", reg_write, 0);
      checkVal("halt_pc_write", pc_write, 0);
      checkVal("halt_mem_read", mem_read, 1);
      cyc(1);
    end
`else
    checkVal("halt_off_state", state, 0);
`endif
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    opcode = 6'h01;
    cyc(3);
    checkVal("mid_pre_state", state, 3);
    rst = 1'b1;
    cyc(1);
    checkVal("mid_rst_state", state, 0);
    checkVal("mid_rst_ir_write", ir_write, 0);
    checkVal("mid_rst_pc_write", pc_write, 0);
    checkVal("mid_rst_combo", pc_write_combo, 0);
    checkVal("mid_rst_mem_read", mem_read, 1);
    rst = 1'b0;
    cyc(1);
    checkVal("mid_post_state", state, 1);
    aluCase("alu_sltu", 4'd10, '1, '0, 0);
    aluCase("alu_sra", 4'd8, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000);
    aluCase("alu_srl", 4'd7, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000);
    aluCase("alu_sll_mask", 4'd6, 64'd1, 64'd68, 64'd16);
    aluCase("alu_add_wrap", 4'd0, '1, 64'd1, 0);
    aluCase("alu_nor", 4'd5, 64'h00FF, 64'hFF00_0000_0000_0000, 64'h00FF_FFFF_FFFF_FF00);
    aluCase("alu_pass_b", 4'd13, 64'd3, 64'h1234, 64'h1234);
    aluCase("alu_op14", 4'd14, '1, '1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mc_control_alu.md
MC_CONTROL_ALU -- requirements
Module: mc_control_alu

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 64, ALU operand/result width.
REQ-002 SHALL have parameter OP_SIZE, default 6, opcode width.
REQ-003 SHALL provide port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL provide port opcode, input, OP_SIZE, current IR opcode field.
REQ-006 SHALL provide ports alu_a and alu_b, input, WORD_SIZE, mux-resolved ALU operands.
REQ-007 SHALL provide port alu_out, output, WORD_SIZE, combinational ALU result.
REQ-008 SHALL provide port state, output, 4, current FSM state.
REQ-009 SHALL provide 1-bit outputs pc_write, pc_write_cond, pc_write_combo, mem_get_data (0=PC, 1=ALUOut), mem_read (1=read, 0=write), ir_write, reg_write, alu_src_a (0=PC, 1=regA), reg_track_select (0: RW=alpha, R1=beta, R2=gamma; 1: RW=alpha, R1=beta, R2=alpha).
REQ-010 SHALL provide 2-bit outputs reg_write_data_select (0=MDR, 1=ALUOut, 2=sign-extended big imm), alu_src_b (0=const 4, 1=regB, 2=offset<<2, 3=offset), pc_src (0=ALUOut, 1=jump address, 2=ALU direct); and 4-bit output alu_op.

Function
REQ-011 alu_op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL (by B[5:0]), 7 SRL, 8 SRA, 9 SLT signed, 10 SLTU, 11 EQ, 12 NE, 13 PASS_B; 14-15 output 0.
REQ-012 ADD/SUB SHALL wrap modulo 2^WORD_SIZE; compare ops SHALL output 1 or 0 zero-extended.
REQ-013 pc_write_combo SHALL equal pc_write OR (pc_write_cond AND alu_out[0]).
REQ-014 Opcodes: LD 0x01, ST 0x02, ADD 0x10, SUB 0x11, AND 0x12, OR 0x13, XOR 0x14, SLT 0x15, BEQ 0x20, BNE 0x21, J 0x30, LI 0x31, HALT 0x3F.
REQ-015 States: 0 FETCH, 1 DECODE, 2 MEM_ADDR, 3 MEM_READ, 4 MEM_WB, 5 MEM_WRITE, 6 EXECUTE, 7 ALU_WB, 8 BRANCH, 9 JUMP, 10 LOAD_IMM, 11 HALT.
REQ-016 Transitions: FETCH->DECODE always; DECODE by opcode: LD/ST->MEM_ADDR, ALU ops->EXECUTE, BEQ/BNE->BRANCH, J->JUMP, LI->LOAD_IMM, HALT->HALT, unknown->FETCH; MEM_ADDR->MEM_READ (LD) or MEM_WRITE (ST); MEM_READ->MEM_WB; EXECUTE->ALU_WB; MEM_WB, MEM_WRITE, ALU_WB, BRANCH, JUMP, LOAD_IMM->FETCH.
REQ-017 Cycle counts: LD 5, ST 4, ALU ops 4, BEQ/BNE 3, J 3, LI 3, unknown 2.
REQ-018 Outputs SHALL be combinational in state (and opcode where stated); unlisted 1-bit enables 0, mem_read 1, selects 0, alu_op ADD.
REQ-019 FETCH: mem_get_data 0, ir_write 1, alu_src_a 0, alu_src_b 0, pc_src 2, pc_write 1.
REQ-020 DECODE: alu_src_a 0, alu_src_b 2, ADD (branch target to ALUOut).
REQ-021 MEM_ADDR: alu_src_a 1, alu_src_b 3, reg_track_select 1; MEM_READ: mem_get_data 1; MEM_WB: reg_write 1, reg_write_data_select 0, reg_track_select 1; MEM_WRITE: mem_get_data 1, mem_read 0, reg_track_select 1.
REQ-022 EXECUTE: alu_src_a 1, alu_src_b 1, alu_op per opcode (ADD,SUB,AND,OR,XOR,SLT); ALU_WB: reg_write 1, reg_write_data_select 1.
REQ-023 BRANCH: alu_src_a 1, alu_src_b 1, alu_op EQ (BEQ) or NE (BNE), pc_write_cond 1, pc_src 0, reg_track_select 1.
REQ-024 JUMP: pc_write 1, pc_src 1; LOAD_IMM: reg_write 1, reg_write_data_select 2.
REQ-025 HALT: state held; all write enables 0, mem_read 1.

Reset
REQ-026 rst high at a clk edge SHALL load state FETCH, overriding any transition, including mid-instruction.
REQ-027 While rst is high, pc_write, pc_write_cond, ir_write, reg_write SHALL be 0 and mem_read 1.

Configuration
REQ-028 With CTRL_HALT_EN defined, opcode 0x3F SHALL enter HALT until reset; without it, 0x3F SHALL be treated as unknown (DECODE->FETCH) and HALT unreachable.

Structure
REQ-029 Package mc_ctrl_pkg SHALL hold opcode constants, state encoding, ALU op codes, select encodings.
REQ-030 ALU SHALL be sub-module mc_alu (alu_a, alu_b, alu_op -> alu_out); FSM and decode in top.

Verification
REQ-031 Reset, then opcode 0x01 held: states 0,1,2,3,4,0; reg_write only in state 4.
REQ-032 opcode 0x02: states 0,1,2,5,0; mem_read 0 only in state 5.
REQ-033 EXECUTE with opcode 0x11, alu_a 5, alu_b 7: alu_out 0xFFFF_FFFF_FFFF_FFFE.
REQ-034 BRANCH with BEQ, alu_a = alu_b = 9: pc_write_combo 1; alu_b 8: pc_write_combo 0.
REQ-035 SLT alu_a -1, alu_b 0 -> 1; SLTU same operands -> 0; SRA 0x8000_0000_0000_0000 by 4 -> 0xF800_0000_0000_0000.
REQ-036 rst asserted in MEM_READ: next state FETCH, write enables 0 during reset; with CTRL_HALT_EN, opcode 0x3F stays in state 11 for 10 cycles.
